renas_ahb_sram_slave: RTL and testbench

//  AHB-Lite responder for the renas mcu on-chip SRAM; it is the slave end of the CPU's AHB master.

---
 rtl/renas_ahb_sram_slave.sv | 147 ++++++++++++++
 tb/tb_renas_ahb_sram_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/renas_ahb_sram_slave.sv
// AHB-Lite responder for the renas MCU on-chip SRAM: byte/half/word transfers,
// programmable data-phase wait states, ERROR response for illegal accesses.
module renas_ahb_sram_slave #(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int          IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b1111;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]      r_mem [MEM_DEPTH];
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_lanes;
  logic [31:0]      r_hrdata;
  logic             r_hreadyout;
  logic             r_hresp;

  logic [31:0]      w_off;
  logic [31:0]      w_idx32;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_wr_done;
  logic             w_fwd;
  logic [31:0]      w_rd_word;
  logic             w_unused_ok;

  assign w_unused_ok = htrans[0];

  // Address-phase decode: word index and legality of the requested transfer
  assign w_off   = haddr - BASE_ADDR;
  assign w_idx32 = w_off >> 2;
  assign w_idx   = w_idx32[IDX_W-1:0];
  assign w_err   = (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                 | (haddr < BASE_ADDR)
                 | (w_idx32 >= DEPTH);

  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_ERR2)
                      || ((r_state == S_DATA) && (r_cnt == 4'd0));
  assign w_accept     = hsel & htrans[1] & hready & w_can_accept;

  // A write completes in the final data-phase cycle; a read accepted on that
  // same edge to the same word sees the merged value without an extra stall.
  assign w_wr_done = (r_state == S_DATA) && (r_cnt == 4'd0) && r_write;
  assign w_fwd     = w_wr_done && (r_idx == w_idx);
  assign w_rd_word = w_fwd ? lane_merge(r_mem[w_idx], hwdata, r_lanes) : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (!rst && w_wr_done) begin
      for (int i = 0; i < 4; i++) begin
        if (r_lanes[i]) r_mem[r_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_lanes     <= 4'b0000;
      r_hrdata    <= 32'h0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else if (w_accept) begin
      if (w_err) begin
        r_state     <= S_ERR1;
        r_write     <= 1'b0;
        r_cnt       <= 4'd0;
        r_hreadyout <= 1'b0;
        r_hresp     <= 1'b1;
      end else begin
        r_state     <= S_DATA;
        r_cnt       <= WS;
        r_write     <= hwrite;
        r_idx       <= w_idx;
        r_lanes     <= lane_mask(hsize, haddr[1:0]);
        r_hreadyout <= (WS == 4'd0);
        r_hresp     <= 1'b0;
        if (!hwrite && (WS == 4'd0)) r_hrdata <= w_rd_word;
      end
    end else if ((r_state == S_DATA) && (r_cnt != 4'd0)) begin
      r_cnt       <= r_cnt - 4'd1;
      r_hreadyout <= (r_cnt == 4'd1);
      if ((r_cnt == 4'd1) && !r_write) r_hrdata <= r_mem[r_idx];
    end else if (r_state == S_ERR1) begin
      r_state     <= S_ERR2;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b1;
    end else begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end
  end

  assign hrdata    = r_hrdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule

// File: tb/tb_renas_ahb_sram_slave.sv
// Directed bench for renas_ahb_sram_slave: one zero-wait instance and one
// two-wait-state instance share the address/data buses, selected by hsel.
module tb_renas_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  renas_ahb_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hreadyout0), .hrdata(hrdata0),
    .hreadyout(hreadyout0), .hresp(hresp0));

  renas_ahb_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hreadyout1), .hrdata(hrdata1),
    .hreadyout(hreadyout1), .hresp(hresp1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel0  = (d == 0);
    hsel1  = (d == 1);
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    haddr = 32'h0; hsize = 3'd2; hwdata = 32'h0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready0 got %b want 1", hreadyout0); end
    n_tests++; if (hresp0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp0 got %b want 0", hresp0); end
    n_tests++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want 0", hrdata0); end
    n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1 got %b want 1", hreadyout1); end
    n_tests++; if (hresp1 !== 1'b0) begin n_fail++; $display("FAIL reset_resp1 got %b want 0", hresp1); end
    n_tests++; if (hrdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h want 0", hrdata1); end
  endtask

  task automatic test_word_rw();
    step();
    drive_addr(0, 32'h10, 1'b1, 3'd2);
    step();
    hwdata = 32'hDEADBEEF;
    drive_addr(0, 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    n_tests++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL t1_wr_nostall got %b want 1", hreadyout0); end
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hrdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_rdata got %h want deadbeef", hrdata0); end
    n_tests++; if (hresp0 !== 1'b0) begin n_fail++; $display("FAIL t1_resp got %b want 0", hresp0); end
    n_tests++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL t1_rd_nostall got %b want 1", hreadyout0); end
  endtask

  task automatic test_byte_lane();
    step();
    drive_addr(0, 32'h20, 1'b1, 3'd2);
    step();
    hwdata = 32'h11223344;
    drive_addr(0, 32'h23, 1'b1, 3'd0);
    step();
    hwdata = 32'hA5000000;
    drive_addr(0, 32'h20, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hrdata0 !== 32'hA5223344) begin n_fail++; $display("FAIL t2_byte_merge got %h want a5223344", hrdata0); end
  endtask

  task automatic test_forwarding();
    step();
    drive_addr(0, 32'h30, 1'b1, 3'd2);
    step();
    hwdata = 32'h0;
    drive_addr(0, 32'h44, 1'b1, 3'd2);
    step();
    hwdata = 32'hCAFEF00D;
    drive_addr(0, 32'h32, 1'b1, 3'd1);
    step();
    hwdata = 32'hBEEF0000;
    drive_addr(0, 32'h30, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hrdata0 !== 32'hBEEF0000) begin n_fail++; $display("FAIL t3_half_fwd got %h want beef0000", hrdata0); end
    step();
    drive_addr(0, 32'h40, 1'b1, 3'd2);
    step();
    hwdata = 32'h12345678;
    drive_addr(0, 32'h44, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hrdata0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t3_other_idx got %h want cafef00d", hrdata0); end
  endtask

  task automatic test_error();
    step();
    drive_addr(0, 32'h00, 1'b1, 3'd2);
    step();
    hwdata = 32'h55AA55AA;
    drive_addr(0, 32'h01, 1'b1, 3'd1);
    step();
    hwdata = 32'hFFFFFFFF;
    drive_idle();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b10) begin n_fail++; $display("FAIL t4_err1 got resp/ready %b%b want 10", hresp0, hreadyout0); end
    step();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b11) begin n_fail++; $display("FAIL t4_err2 got resp/ready %b%b want 11", hresp0, hreadyout0); end
    n_tests++; if (hrdata0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t4_rdata_hold got %h want cafef00d", hrdata0); end
    step();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b01) begin n_fail++; $display("FAIL t4_idle got resp/ready %b%b want 01", hresp0, hreadyout0); end
    drive_addr(0, 32'h00, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hrdata0 !== 32'h55AA55AA) begin n_fail++; $display("FAIL t4_no_write got %h want 55aa55aa", hrdata0); end
    step();
    drive_addr(0, 32'h06, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b10) begin n_fail++; $display("FAIL t4_word_misalign got %b%b want 10", hresp0, hreadyout0); end
    step();
    step();
    drive_addr(0, 32'h08, 1'b0, 3'd3);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b10) begin n_fail++; $display("FAIL t4_oversize got %b%b want 10", hresp0, hreadyout0); end
    step();
    step();
  endtask

  task automatic test_wait_states();
    step();
    drive_addr(1, 32'h10, 1'b1, 3'd2);
    step();
    hwdata = 32'hDEADBEEF;
    drive_idle();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b0) begin n_fail++; $display("FAIL t5_wr_stall1 got %b want 0", hreadyout1); end
    step();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b0) begin n_fail++; $display("FAIL t5_wr_stall2 got %b want 0", hreadyout1); end
    step();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL t5_wr_done got %b want 1", hreadyout1); end
    drive_addr(1, 32'h10, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b0) begin n_fail++; $display("FAIL t5_rd_stall1 got %b want 0", hreadyout1); end
    step();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b0) begin n_fail++; $display("FAIL t5_rd_stall2 got %b want 0", hreadyout1); end
    step();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL t5_rd_done got %b want 1", hreadyout1); end
    n_tests++; if (hrdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t5_rdata got %h want deadbeef", hrdata1); end
    step();
  endtask

  task automatic test_range_and_reset();
    drive_addr(0, 32'h1000, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b10) begin n_fail++; $display("FAIL t6_range_err1 got %b%b want 10", hresp0, hreadyout0); end
    step();
    @(negedge clk);
    n_tests++; if ({hresp0, hreadyout0} !== 2'b11) begin n_fail++; $display("FAIL t6_range_err2 got %b%b want 11", hresp0, hreadyout0); end
    step();
    drive_addr(1, 32'h10, 1'b1, 3'd2);
    step();
    hwdata = 32'h0BADF00D;
    drive_idle();
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b0) begin n_fail++; $display("FAIL t6_stall got %b want 0", hreadyout1); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL t6_rst_ready got %b want 1", hreadyout1); end
    n_tests++; if (hresp1 !== 1'b0) begin n_fail++; $display("FAIL t6_rst_resp got %b want 0", hresp1); end
    n_tests++; if (hrdata1 !== 32'h0) begin n_fail++; $display("FAIL t6_rst_rdata got %h want 0", hrdata1); end
    step();
    drive_addr(1, 32'h10, 1'b0, 3'd2);
    step();
    drive_idle();
    step();
    step();
    @(negedge clk);
    n_tests++; if (hrdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t6_write_dropped got %h want deadbeef", hrdata1); end
    n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL t6_rd_done got %b want 1", hreadyout1); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_forwarding();
    test_error();
    test_wait_states();
    test_range_and_reset();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
